// File: rtl/menshen_h2c_pkg.sv
// menshen_h2c_pkg: shared tuser layout, FSM states and beat geometry for the QDMA H2C adapter
package menshen_h2c_pkg;
  localparam int BYTES_PER_BEAT = 64;
  localparam int TU_LEN_LSB = 0;
  localparam int TU_LEN_W = 16;
  localparam int TU_PORT_LSB = 16;
  localparam int TU_PORT_W = 3;
  localparam int TU_QID_LSB = 19;
  localparam int TU_QID_W = 11;
  localparam int TU_MDATA_LSB = 32;
  localparam int TU_MDATA_W = 32;
  localparam int TU_ERR_BIT = 64;
  typedef enum logic [1:0] {SOP, FWD, DROP} h2c_state_t;
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry register slice; ready is registered so it never depends on downstream ready
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic [W-1:0] r_mem [2];
  logic         r_wp, r_rp, r_ready;
  logic [1:0]   r_cnt, w_cnt_nxt;
  logic         w_push, w_pop;
  assign w_push = i_valid && r_ready;
  assign w_pop = (r_cnt != 2'd0) && i_ready;
  assign w_cnt_nxt = r_cnt + 2'(w_push) - 2'(w_pop);
  assign o_ready = r_ready;
  assign o_valid = r_cnt != 2'd0;
  assign o_data = r_mem[r_rp];
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_cnt <= '0;
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_ready <= w_cnt_nxt != 2'd2;
      if (w_push) r_wp <= ~r_wp;
      if (w_pop) r_rp <= ~r_rp;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end
endmodule

// File: rtl/qdma_h2c_adapter.sv
// qdma_h2c_adapter: QDMA H2C (mty/sideband) to Menshen tkeep/tuser stream with
// error/zero-byte filtering, per-packet length and traffic statistics.
module qdma_h2c_adapter
  import menshen_h2c_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int TUSER_W = 128,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                s_axis_qdma_h2c_tvalid,
  output logic                s_axis_qdma_h2c_tready,
  input  logic [DATA_W-1:0]   s_axis_qdma_h2c_tdata,
  input  logic                s_axis_qdma_h2c_tlast,
  input  logic [5:0]          s_axis_qdma_h2c_tuser_mty,
  input  logic [10:0]         s_axis_qdma_h2c_tuser_qid,
  input  logic [2:0]          s_axis_qdma_h2c_tuser_port_id,
  input  logic                s_axis_qdma_h2c_tuser_err,
  input  logic                s_axis_qdma_h2c_tuser_zero_byte,
  input  logic [31:0]         s_axis_qdma_h2c_tuser_mdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic [TUSER_W-1:0]  m_axis_tuser,
  output logic [CNT_W-1:0]    stat_pkt_cnt,
  output logic [CNT_W-1:0]    stat_byte_cnt,
  output logic [CNT_W-1:0]    stat_drop_cnt
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int SB_W = DATA_W + KEEP_W + 1 + TUSER_W;
  h2c_state_t         r_state, w_state_nxt;
  logic [15:0]        r_len, w_len;
  logic [CNT_W-1:0]   r_pkt_cnt, r_byte_cnt, r_drop_cnt;
  logic               w_ready, w_hs, w_last, w_to_drop, w_trunc, w_fwd, w_olast;
  logic               w_good_last, w_drop_end;
  logic [6:0]         w_bytes;
  logic [16:0]        w_sum;
  logic [KEEP_W-1:0]  w_keep;
  logic [TUSER_W-1:0] w_tuser;
  logic [SB_W-1:0]    w_sb_out;
  assign w_last = s_axis_qdma_h2c_tlast;
  assign w_hs = s_axis_qdma_h2c_tvalid && w_ready;
  // Beats after this one belong to a dropped packet (or this beat closes one).
  assign w_to_drop = (r_state == DROP) ||
                     (r_state == SOP && (s_axis_qdma_h2c_tuser_zero_byte || s_axis_qdma_h2c_tuser_err)) ||
                     (r_state == FWD && s_axis_qdma_h2c_tuser_err);
  always_ff @(posedge clk or posedge areset) begin
    if (areset) r_state <= SOP;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state;
    if (w_hs) w_state_nxt = w_last ? SOP : (w_to_drop ? DROP : FWD);
  end
  always_comb begin
    w_trunc = (r_state == FWD) && s_axis_qdma_h2c_tuser_err;
    w_fwd = w_hs && (r_state == FWD ||
            (r_state == SOP && !s_axis_qdma_h2c_tuser_zero_byte && !s_axis_qdma_h2c_tuser_err));
    w_olast = w_last || w_trunc;
    w_bytes = w_last ? 7'(BYTES_PER_BEAT) - {1'b0, s_axis_qdma_h2c_tuser_mty} : 7'(BYTES_PER_BEAT);
    w_sum = {1'b0, r_len} + {10'd0, w_bytes};
    w_len = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    w_keep = w_last ? {KEEP_W{1'b1}} >> s_axis_qdma_h2c_tuser_mty : {KEEP_W{1'b1}};
    w_tuser = '0;
    w_tuser[TU_LEN_LSB +: TU_LEN_W] = w_olast ? w_len : 16'd0;
    w_tuser[TU_PORT_LSB +: TU_PORT_W] = s_axis_qdma_h2c_tuser_port_id;
    w_tuser[TU_QID_LSB +: TU_QID_W] = s_axis_qdma_h2c_tuser_qid;
    w_tuser[TU_MDATA_LSB +: TU_MDATA_W] = s_axis_qdma_h2c_tuser_mdata;
    w_tuser[TU_ERR_BIT] = w_trunc;
    w_good_last = w_fwd && w_last && !w_trunc;
    w_drop_end = w_hs && w_last && w_to_drop;
  end
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_len <= '0;
      r_pkt_cnt <= '0;
      r_byte_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_hs) r_len <= w_last ? 16'd0 : w_len;
      if (w_good_last) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      if (w_good_last) r_byte_cnt <= r_byte_cnt + CNT_W'(w_len);
      if (w_drop_end) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end
  axis_skid_buffer #(.W(SB_W)) u_skid (
    .clk     (clk),
    .areset  (areset),
    .i_valid (w_fwd),
    .o_ready (w_ready),
    .i_data  ({s_axis_qdma_h2c_tdata, w_keep, w_olast, w_tuser}),
    .o_valid (m_axis_tvalid),
    .i_ready (m_axis_tready),
    .o_data  (w_sb_out)
  );
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = w_sb_out;
  assign s_axis_qdma_h2c_tready = w_ready;
  assign stat_pkt_cnt = r_pkt_cnt;
  assign stat_byte_cnt = r_byte_cnt;
  assign stat_drop_cnt = r_drop_cnt;
endmodule
